// File: rtl/sort_driver.sv
// Batch front end for an external 8-element sorter: fill, start, feed, wait, drain, recover.
// Optional capture-time order/sum checker: define SORT_DRIVER_ORDER_CHECK_EN to add order_err.
module sort_driver #(
  parameter int WIDTH   = 8,
  parameter int N_ELEM  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    sort_start,
  output logic [WIDTH-1:0]        sort_data,
  output logic                    sort_reset,
  input  logic                    sort_done,
  input  logic [N_ELEM*WIDTH-1:0] sort_result,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
`ifdef SORT_DRIVER_ORDER_CHECK_EN
  output logic                    order_err,
`endif
  output logic                    timeout_err
);

  localparam int CNT_W  = $clog2(N_ELEM);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N_ELEM - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {FILL, START, FEED, WAIT, DRAIN, RECOVER} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_err_q, timeout_err_d;
  logic [WIDTH-1:0]  elem_buf_q [N_ELEM];
  logic [WIDTH-1:0]  elem_buf_d [N_ELEM];
  logic [WIDTH-1:0]  res_q [N_ELEM];
  logic [WIDTH-1:0]  res_d [N_ELEM];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FILL;
      cnt_q         <= '0;
      k_q           <= '0;
      wait_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      k_q           <= k_d;
      wait_q        <= wait_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Data buffers need no reset: the counters and state decide what is ever visible.
  always_ff @(posedge clk) begin
    elem_buf_q <= elem_buf_d;
    res_q      <= res_d;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    k_d           = k_q;
    wait_d        = wait_q;
    timeout_err_d = timeout_err_q;
    elem_buf_d    = elem_buf_q;
    res_d         = res_q;
    in_ready      = 1'b0;
    sort_start    = 1'b0;
    sort_data     = '0;
    out_valid     = 1'b0;
    out_data      = '0;
    out_last      = 1'b0;

    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          elem_buf_d[cnt_q] = in_data;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) state_d = START;
        end
      end
      START: begin
        sort_start = 1'b1;
        cnt_d      = '0;
        state_d    = FEED;
      end
      FEED: begin
        sort_data = elem_buf_q[cnt_q];
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_IDX) begin
          wait_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Completion on the final allowed cycle still wins over the timeout.
        if (sort_done) begin
          for (int i = 0; i < N_ELEM; i++) res_d[i] = sort_result[i*WIDTH +: WIDTH];
          k_d     = '0;
          state_d = DRAIN;
        end else if (wait_q == WAIT_LIM) begin
          timeout_err_d = 1'b1;
          state_d       = RECOVER;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = res_q[k_q];
        out_last  = (k_q == LAST_IDX);
        if (out_ready) begin
          k_d = k_q + CNT_W'(1);
          if (k_q == LAST_IDX) state_d = RECOVER;
        end
      end
      RECOVER: begin
        cnt_d   = '0;
        k_d     = '0;
        wait_d  = '0;
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase

    if (reset) begin
      in_ready   = 1'b0;
      sort_start = 1'b0;
      sort_data  = '0;
      out_valid  = 1'b0;
      out_data   = '0;
      out_last   = 1'b0;
    end
  end

  assign sort_reset  = reset | (state_q == RECOVER);
  assign timeout_err = timeout_err_q & ~reset;

`ifdef SORT_DRIVER_ORDER_CHECK_EN
  localparam int SUM_W = WIDTH + 3;

  logic             order_err_q, order_err_d;
  logic [SUM_W-1:0] buf_sum, res_sum;
  logic             unsorted;

  // Sum comparison is a cheap multiset check between what was fed and what came back.
  always_comb begin
    buf_sum  = '0;
    res_sum  = '0;
    unsorted = 1'b0;
    for (int i = 0; i < N_ELEM; i++) begin
      buf_sum = buf_sum + SUM_W'(elem_buf_q[i]);
      res_sum = res_sum + SUM_W'(sort_result[i*WIDTH +: WIDTH]);
    end
    for (int i = 0; i < N_ELEM - 1; i++) begin
      if (sort_result[i*WIDTH +: WIDTH] > sort_result[(i+1)*WIDTH +: WIDTH]) unsorted = 1'b1;
    end
    order_err_d = order_err_q;
    if (state_q == WAIT && sort_done && (unsorted || buf_sum != res_sum)) order_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) order_err_q <= 1'b0;
    else       order_err_q <= order_err_d;
  end

  assign order_err = order_err_q & ~reset;
`endif

endmodule

// File: tb/tb_sort_driver.sv
// Directed bench for sort_driver: per-cycle vector table for a full batch, then
// hand-written sequences for drain stalls, timeout boundary, timeout abort and mid-batch reset.
module tb_sort_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        sort_start;
  logic [7:0]  sort_data;
  logic        sort_reset;
  logic        sort_done;
  logic [63:0] sort_result;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        timeout_err;
`ifdef SORT_DRIVER_ORDER_CHECK_EN
  logic        order_err;
`endif

  sort_driver #(.WIDTH(8), .N_ELEM(8), .TIMEOUT(255)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sort_start  (sort_start),
    .sort_data   (sort_data),
    .sort_reset  (sort_reset),
    .sort_done   (sort_done),
    .sort_result (sort_result),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
`ifdef SORT_DRIVER_ORDER_CHECK_EN
    .order_err   (order_err),
`endif
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] batchVals [8];
  logic [7:0] resVals   [8];

  typedef struct {
    string       tag;
    logic        rst;
    logic        iv;
    logic [7:0]  id;
    logic        done;
    logic        ordy;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [21:0] packExp(logic ir, logic ss, logic [7:0] sd, logic sr,
                                          logic ov, logic [7:0] od, logic ol, logic te);
    return {ir, ss, sd, sr, ov, od, ol, te};
  endfunction

  function automatic logic [21:0] dutOut();
    return {in_ready, sort_start, sort_data, sort_reset, out_valid, out_data, out_last, timeout_err};
  endfunction

  function automatic void addVec(string tag, logic rst, logic iv, logic [7:0] id,
                                 logic done, logic [21:0] exp);
    vec_t v;
    v.tag  = tag;
    v.rst  = rst;
    v.iv   = iv;
    v.id   = id;
    v.done = done;
    v.ordy = 1'b1;
    v.exp  = exp;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset     = v.rst;
    in_valid  = v.iv;
    in_data   = v.id;
    sort_done = v.done;
    out_ready = v.ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadResult();
    for (int i = 0; i < 8; i++) sort_result[i*8 +: 8] = resVals[i];
  endtask

  // Presents batchVals on eight consecutive cycles; returns in the START cycle.
  task automatic fillBatch();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = batchVals[i];
      tick();
    end
    in_valid = 1'b0;
    in_data  = 8'd0;
  endtask

  // Called in the first DRAIN cycle with out_ready=1; returns in the cycle after RECOVER.
  task automatic drainExpect(input string name);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s_out%0d", name, i), 32'({out_valid, out_last, out_data}),
                  32'({1'b1, (i == 7), resVals[i]}));
      tick();
    end
    checkOutput({name, "_recover"}, 32'({sort_reset, out_valid, in_ready}), 32'(3'b100));
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [7:0] got[$];
    int         lastCnt;
    logic       lastOnFinal;
    logic       prevStall;
    logic [7:0] prevData;
    logic       sawValid;

    reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; sort_done = 1'b0; out_ready = 1'b1;

    batchVals = '{8'd8, 8'd3, 8'd7, 8'd1, 8'd5, 8'd2, 8'd6, 8'd4};
    resVals   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    loadResult();

    // Full batch, cycle by cycle: done arrives in the 20th WAIT cycle.
    repeat (2) addVec("reset", 1, 0, 0, 0, packExp(0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) addVec("fill", 0, 1, batchVals[i], 0, packExp(1, 0, 0, 0, 0, 0, 0, 0));
    addVec("start", 0, 0, 0, 0, packExp(0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) addVec("feed", 0, 0, 0, 0, packExp(0, 0, batchVals[i], 0, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) addVec("wait", 0, 0, 0, (i == 19), packExp(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) addVec("drain", 0, 0, 0, 0, packExp(0, 0, 0, 0, 1, 8'(i + 1), (i == 7), 0));
    addVec("recover", 0, 0, 0, 0, packExp(0, 0, 0, 1, 0, 0, 0, 0));
    repeat (2) addVec("fill_idle", 0, 0, 0, 0, packExp(1, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[idx]) begin
      applyStimulus(vecs[idx]);
      #1;
      checkOutput($sformatf("%s[%0d]", vecs[idx].tag, idx), 32'(dutOut()), 32'(vecs[idx].exp));
      @(posedge clk);
      #1;
    end

    // Drain with out_ready pattern 1,0,0,1,0,0,...
    batchVals = '{8'd40, 8'd10, 8'd80, 8'd20, 8'd70, 8'd30, 8'd60, 8'd50};
    resVals   = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    loadResult();
    fillBatch();
    repeat (9) tick();
    sort_done = 1'b1;
    tick();
    sort_done   = 1'b0;
    lastCnt     = 0;
    lastOnFinal = 1'b0;
    prevStall   = 1'b0;
    prevData    = 8'd0;
    for (int c = 0; c < 60 && got.size() < 8; c++) begin
      out_ready = (c % 3 == 0);
      #1;
      if (prevStall)
        checkOutput($sformatf("stall_hold%0d", c), 32'({out_valid, out_data}), 32'({1'b1, prevData}));
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (out_last) begin
          lastCnt++;
          lastOnFinal = (got.size() == 8);
        end
      end
      tick();
    end
    checkOutput("stall_count", 32'(got.size()), 32'd8);
    foreach (got[i]) checkOutput($sformatf("stall_elem%0d", i), 32'(got[i]), 32'(resVals[i]));
    checkOutput("stall_last", 32'({lastCnt[7:0], lastOnFinal}), 32'({8'd1, 1'b1}));
    checkOutput("stall_recover", 32'(sort_reset), 32'd1);
    out_ready = 1'b1;
    tick();

    // Done on the 255th WAIT cycle: capture wins over timeout.
    fillBatch();
    repeat (9) tick();
    repeat (254) tick();
    sort_done = 1'b1;
    #1;
    checkOutput("limit_no_err_yet", 32'(timeout_err), 32'd0);
    tick();
    sort_done = 1'b0;
    drainExpect("limit");
    checkOutput("limit_no_err", 32'(timeout_err), 32'd0);

    // Sorter never finishes: abort after 255 WAIT cycles.
    fillBatch();
    repeat (9) tick();
    sawValid = 1'b0;
    for (int c = 0; c < 254; c++) begin
      if (out_valid) sawValid = 1'b1;
      tick();
    end
    if (out_valid) sawValid = 1'b1;
    checkOutput("timeout_before", 32'(timeout_err), 32'd0);
    tick();
    checkOutput("timeout_set", 32'({timeout_err, sort_reset, out_valid}), 32'(3'b110));
    checkOutput("timeout_no_valid", 32'(sawValid), 32'd0);
    tick();
    checkOutput("timeout_fill", 32'({in_ready, timeout_err, sort_reset}), 32'(3'b110));

`ifdef SORT_DRIVER_ORDER_CHECK_EN
    batchVals = '{8'd5, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4};
    resVals   = '{8'd1, 8'd2, 8'd4, 8'd3, 8'd5, 8'd6, 8'd7, 8'd8};
    loadResult();
    fillBatch();
    repeat (9) tick();
    checkOutput("order_before", 32'(order_err), 32'd0);
    sort_done = 1'b1;
    tick();
    sort_done = 1'b0;
    checkOutput("order_set", 32'(order_err), 32'd1);
    drainExpect("order");
    checkOutput("order_sticky", 32'(order_err), 32'd1);
`endif

    // Reset on the third FEED cycle, then a clean batch.
    batchVals = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88};
    fillBatch();
    checkOutput("rst_pre_start", 32'(sort_start), 32'd1);
    repeat (3) tick();
    checkOutput("rst_pre_feed", 32'(sort_data), 32'd33);
    reset = 1'b1;
    #1;
    checkOutput("rst_outputs", 32'(dutOut()), 32'(packExp(0, 0, 0, 1, 0, 0, 0, 0)));
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_release", 32'({in_ready, sort_reset, timeout_err, sort_start}), 32'(4'b1000));
`ifdef SORT_DRIVER_ORDER_CHECK_EN
    checkOutput("rst_order_clear", 32'(order_err), 32'd0);
`endif
    batchVals = '{8'd9, 8'd200, 8'd33, 8'd0, 8'd255, 8'd17, 8'd128, 8'd64};
    resVals   = '{8'd0, 8'd9, 8'd17, 8'd33, 8'd64, 8'd128, 8'd200, 8'd255};
    loadResult();
    fillBatch();
    checkOutput("post_start", 32'(sort_start), 32'd1);
    tick();
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("post_feed%0d", i), 32'(sort_data), 32'(batchVals[i]));
      tick();
    end
    repeat (4) tick();
    sort_done = 1'b1;
    tick();
    sort_done = 1'b0;
    drainExpect("post");
    checkOutput("post_flags", 32'({timeout_err, in_ready}), 32'(2'b01));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
